// File: rtl/mem_pkg.sv
// Shared widths and the grant encoding for the memory access unit.
// Imported by the arbiter, the bus interface and the top.
package mem_pkg;

   localparam int ADDR_W     = 5;
   localparam int DATA_W     = 8;
   localparam int STARVE_MAX = 3;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_IF,
      GNT_D
   } gnt_e;

endpackage : mem_pkg

// File: rtl/mem_access_unit_if.sv
// Fetch and data request/response channels between the datapath and the unit.
// The datapath side is the master; the access unit is the slave.
interface mem_access_unit_if #(
   parameter int ADDR_W = mem_pkg::ADDR_W,
   parameter int DATA_W = mem_pkg::DATA_W
);

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ready;
   logic              if_valid;
   logic [DATA_W-1:0] if_rdata;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ready;
   logic              d_valid;
   logic [DATA_W-1:0] d_rdata;

   modport master (
      output if_req, if_addr,
      input  if_ready, if_valid, if_rdata,
      output d_req, d_we, d_addr, d_wdata,
      input  d_ready, d_valid, d_rdata
   );

   modport slave (
      input  if_req, if_addr,
      output if_ready, if_valid, if_rdata,
      input  d_req, d_we, d_addr, d_wdata,
      output d_ready, d_valid, d_rdata
   );

endinterface : mem_access_unit_if

// File: rtl/mem_arb.sv
// Fetch/data arbiter: data wins by default, fetch is forced after STARVE_MAX
// consecutive data grants that kept a pending fetch waiting.
module mem_arb
   import mem_pkg::*;
#(
   parameter int STARVE_MAX = mem_pkg::STARVE_MAX
) (
   input  logic clk,
   input  logic rst,
   input  logic if_req,
   input  logic d_req,
   output gnt_e gnt
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] starve_cnt;

   // NOTE: every output of a combinational block gets a default first so no
   // path leaves it unassigned and a latch is never inferred.
   always_comb begin
      gnt = GNT_NONE;
      if (rst) begin
         gnt = GNT_NONE;
      end else if (d_req && if_req) begin
         gnt = (starve_cnt == CNT_MAX) ? GNT_IF : GNT_D;
      end else if (d_req) begin
         gnt = GNT_D;
      end else if (if_req) begin
         gnt = GNT_IF;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its inputs from before the edge, independent of block order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (!if_req || gnt == GNT_IF) begin
         starve_cnt <= '0;
      end else if (gnt == GNT_D && starve_cnt != CNT_MAX) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

endmodule : mem_arb

// File: rtl/mem_access_unit.sv
// Single-port front end for the main memory: arbitrates fetch and data
// requests onto one combinational-read port and registers the responses.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int ADDR_W     = mem_pkg::ADDR_W,
   parameter int DATA_W     = mem_pkg::DATA_W,
   parameter int STARVE_MAX = mem_pkg::STARVE_MAX
) (
   input  logic              clk,
   input  logic              rst,
   mem_access_unit_if.slave  bus,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout
);

   gnt_e gnt;

   mem_arb #(
      .STARVE_MAX (STARVE_MAX)
   ) u_arb (
      .clk    (clk),
      .rst    (rst),
      .if_req (bus.if_req),
      .d_req  (bus.d_req),
      .gnt    (gnt)
   );

   assign bus.if_ready = (gnt == GNT_IF);
   assign bus.d_ready  = (gnt == GNT_D);

   always_comb begin
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_din  = '0;
      case (gnt)
         GNT_D: begin
            mem_we   = bus.d_we;
            mem_addr = bus.d_addr;
            mem_din  = bus.d_wdata;
         end
         GNT_IF: begin
            mem_addr = bus.if_addr;
         end
         default: ;
      endcase
   end

   // NOTE: asynchronous reset acts immediately, without waiting for a clock,
   // so the response registers are cleared the moment rst rises.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.if_valid <= 1'b0;
         bus.d_valid  <= 1'b0;
         bus.if_rdata <= '0;
         bus.d_rdata  <= '0;
      end else begin
         bus.if_valid <= (gnt == GNT_IF);
         bus.d_valid  <= (gnt == GNT_D);
         if (gnt == GNT_IF) begin
            bus.if_rdata <= mem_dout;
         end
         // Stores respond on d_valid but keep the last loaded word.
         if (gnt == GNT_D && !bus.d_we) begin
            bus.d_rdata <= mem_dout;
         end
      end
   end

endmodule : mem_access_unit

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a preloaded 32x8 memory model.
// Stimulus pushes expected responses; a monitor pops them on each valid pulse.
module tb_mem_access_unit;
   import mem_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic load_mem = 1'b1;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_din;
   logic [DATA_W-1:0] mem_dout;

   logic [DATA_W-1:0] mem     [32];
   logic [DATA_W-1:0] ref_mem [32];
   logic [DATA_W-1:0] if_q [$];
   logic [DATA_W-1:0] d_q  [$];
   logic [DATA_W-1:0] last_load;

   int checks   = 0;
   int failures = 0;

   mem_access_unit_if bus ();

   mem_access_unit dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus.slave),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_din  (mem_din),
      .mem_dout (mem_dout)
   );

   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] pat(input int i);
      logic [DATA_W-1:0] v;
      v = 8'(i * 37 + 27);
      if (i == 3) v = 8'hA5;
      return v;
   endfunction

   assign mem_dout = mem[mem_addr];

   always @(posedge clk) begin
      if (load_mem) begin
         for (int i = 0; i < 32; i++) mem[i] <= pat(i);
      end else if (mem_we) begin
         mem[mem_addr] <= mem_din;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One cycle: sample grant and memory drive at negedge, record expectations.
   task automatic step(input gnt_e exp);
      gnt_e got;
      @(negedge clk);
      check("one_hot_ready", 32'(bus.if_ready && bus.d_ready), 32'd0);
      got = bus.d_ready ? GNT_D : (bus.if_ready ? GNT_IF : GNT_NONE);
      check("grant", 32'(got), 32'(exp));
      case (got)
         GNT_D: begin
            check("mem_addr_d", 32'(mem_addr), 32'(bus.d_addr));
            check("mem_we_d", 32'(mem_we), 32'(bus.d_we));
            if (bus.d_we) begin
               check("mem_din_d", 32'(mem_din), 32'(bus.d_wdata));
               ref_mem[bus.d_addr] = bus.d_wdata;
               d_q.push_back(last_load);
            end else begin
               last_load = ref_mem[bus.d_addr];
               d_q.push_back(last_load);
            end
         end
         GNT_IF: begin
            check("mem_addr_if", 32'(mem_addr), 32'(bus.if_addr));
            check("mem_we_if", 32'(mem_we), 32'd0);
            if_q.push_back(ref_mem[bus.if_addr]);
         end
         default: begin
            check("idle_bus", {23'd0, mem_we, mem_addr, mem_din}, 32'd0);
         end
      endcase
      @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      logic [DATA_W-1:0] e;
      forever begin
         @(posedge clk);
         #2;
         if (bus.if_valid) begin
            if (if_q.size() == 0) begin
               check("unexpected_if_valid", 32'd1, 32'd0);
            end else begin
               e = if_q.pop_front();
               check("if_rdata", 32'(bus.if_rdata), 32'(e));
            end
         end
         if (bus.d_valid) begin
            if (d_q.size() == 0) begin
               check("unexpected_d_valid", 32'd1, 32'd0);
            end else begin
               e = d_q.pop_front();
               check("d_rdata", 32'(bus.d_rdata), 32'(e));
            end
         end
      end
   end

   initial begin : stimulus
      for (int i = 0; i < 32; i++) ref_mem[i] = pat(i);
      last_load   = '0;
      bus.if_req  = 1'b0;
      bus.if_addr = '0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_addr  = '0;
      bus.d_wdata = '0;

      // Reset held while a store to 5 is requested.
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 5'd5; bus.d_wdata = 8'hEE;
      step(GNT_NONE);
      step(GNT_NONE);
      @(negedge clk);
      check("rst_valids", {30'd0, bus.if_valid, bus.d_valid}, 32'd0);
      check("rst_rdata", {16'd0, bus.if_rdata, bus.d_rdata}, 32'd0);
      @(posedge clk); #1;
      bus.d_req = 1'b0; bus.d_we = 1'b0;
      rst = 1'b0; load_mem = 1'b0;
      step(GNT_NONE);
      check("rst_mem5", 32'(mem[5]), 32'(ref_mem[5]));

      // Fetch only from address 3.
      bus.if_req = 1'b1; bus.if_addr = 5'd3;
      step(GNT_IF);
      bus.if_req = 1'b0;
      step(GNT_NONE);

      // Store 3C to 7, then load 7.
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 5'd7; bus.d_wdata = 8'h3C;
      step(GNT_D);
      bus.d_we = 1'b0;
      step(GNT_D);
      bus.d_req = 1'b0;
      step(GNT_NONE);
      check("mem7_stored", 32'(mem[7]), 32'h3C);

      // Contention for five cycles.
      bus.if_req = 1'b1; bus.if_addr = 5'd8;
      bus.d_req  = 1'b1; bus.d_we = 1'b0; bus.d_addr = 5'd9;
      step(GNT_D);
      step(GNT_D);
      step(GNT_D);
      step(GNT_IF);
      step(GNT_D);
      bus.if_req = 1'b0; bus.d_req = 1'b0;
      step(GNT_NONE);

      // Store dropped in the cycle fetch is forced.
      bus.if_req = 1'b1; bus.if_addr = 5'd10;
      bus.d_req  = 1'b1; bus.d_we = 1'b0; bus.d_addr = 5'd11;
      step(GNT_D);
      step(GNT_D);
      step(GNT_D);
      bus.d_we = 1'b1; bus.d_addr = 5'd20; bus.d_wdata = 8'h77;
      step(GNT_IF);
      bus.if_req = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
      step(GNT_NONE);
      step(GNT_NONE);
      check("dropped_mem20", 32'(mem[20]), 32'(pat(20)));

      // Address wrap: 31 then 0 back-to-back.
      bus.if_req = 1'b1; bus.if_addr = 5'd31;
      step(GNT_IF);
      bus.if_addr = 5'd0;
      step(GNT_IF);
      bus.if_req = 1'b0;
      step(GNT_NONE);
      step(GNT_NONE);

      check("if_q_drained", 32'(if_q.size()), 32'd0);
      check("d_q_drained", 32'(d_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_mem_access_unit
